// File: rtl/ecg_pkg.sv
// Shared types and default constants for the ECG R-peak chain
// (also used by the rate calculator and the FIR output logger).
package ecg_pkg;

    localparam int IN_W        = 38;
    localparam int OUT_W       = 16;
    localparam int PKL_INIT    = 4000;
    localparam int REFRACT_LEN = 72;
    localparam int MAX_WIDTH   = 36;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        TRACK   = 2'd1,
        REFRACT = 2'd2
    } det_state_t;

endpackage

// File: rtl/ecg_requant.sv
// Combinational requantizer: arithmetic shift with round-half-up, then
// saturation to a signed OUT_W-bit sample.
module ecg_requant #(
    parameter int IN_W  = ecg_pkg::IN_W,
    parameter int OUT_W = ecg_pkg::OUT_W,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] y_q
);

    localparam logic signed [IN_W:0] HALF =
        {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

    logic signed [IN_W:0]       sum;
    logic signed [IN_W:0]       shr;
    logic [IN_W-OUT_W+1:0]      top_bits;

    // The result fits when every bit above the output sign bit matches it.
    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum      = {y_in[IN_W-1], y_in} + HALF;
        shr      = sum >>> SHIFT;
        top_bits = shr[IN_W:OUT_W-1];
        if (top_bits == '0 || top_bits == '1) begin
            y_q = shr[OUT_W-1:0];
        end else if (shr[IN_W]) begin
            y_q = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            y_q = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ecg_rpeak_detector.sv
// Requantizes the band-pass FIR output and detects R-peaks with an adaptive
// threshold, a bounded peak width and a refractory window.
module ecg_rpeak_detector
    import ecg_pkg::*;
#(
    parameter int IN_W        = ecg_pkg::IN_W,
    parameter int OUT_W       = ecg_pkg::OUT_W,
    parameter int SHIFT       = 15,
    parameter int PKL_INIT    = ecg_pkg::PKL_INIT,
    parameter int REFRACT_LEN = ecg_pkg::REFRACT_LEN,
    parameter int MAX_WIDTH   = ecg_pkg::MAX_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] y_q,
    output logic                    y_q_valid,
    output logic                    peak_valid,
    output logic [31:0]             peak_idx,
    output logic [OUT_W-1:0]        peak_amp,
    output logic [15:0]             beat_count
);

    localparam int RC_W = $clog2(REFRACT_LEN + 1);
    localparam int WD_W = $clog2(MAX_WIDTH + 1);
    localparam logic [OUT_W-1:0]        AMP_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [OUT_W-1:0] y_q_next;
    logic [OUT_W-1:0]        amp_next;
    logic [OUT_W-1:0]        amp_q;
    logic                    amp_valid;
    logic [31:0]             sample_idx;

    det_state_t              state_q, state_d;
    logic [OUT_W-1:0]        cand_amp_q, cand_amp_d;
    logic [31:0]             cand_idx_q, cand_idx_d;
    logic [WD_W-1:0]         width_q, width_d;
    logic [RC_W-1:0]         rcnt_q, rcnt_d;
    logic                    emit;

    logic [OUT_W-1:0]        pkl_q;
    logic [OUT_W-1:0]        thr;
    logic                    above;
    logic [OUT_W+1:0]        pkl_mix;

    ecg_requant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .y_in (y_in),
        .y_q  (y_q_next)
    );

    // Magnitude with the most negative code folded onto the positive limit.
    always_comb begin
        if (!y_q[OUT_W-1]) begin
            amp_next = y_q;
        end else if (y_q == Q_MIN) begin
            amp_next = AMP_MAX;
        end else begin
            amp_next = ~y_q + OUT_W'(1);
        end
    end

    // Stages 1 and 2: data loads only behind a valid sample, valid bits just follow.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q       <= '0;
            y_q_valid <= 1'b0;
            amp_q     <= '0;
            amp_valid <= 1'b0;
        end else begin
            y_q_valid <= in_valid;
            amp_valid <= y_q_valid;
            if (in_valid) begin
                y_q <= y_q_next;
            end
            if (y_q_valid) begin
                amp_q <= amp_next;
            end
        end
    end

    assign thr   = pkl_q >> 1;
    assign above = amp_q > thr;

    always_comb begin
        state_d    = state_q;
        cand_amp_d = cand_amp_q;
        cand_idx_d = cand_idx_q;
        width_d    = width_q;
        rcnt_d     = rcnt_q;
        emit       = 1'b0;
        if (amp_valid) begin
            case (state_q)
                SEARCH: begin
                    if (above) begin
                        state_d    = TRACK;
                        cand_amp_d = amp_q;
                        cand_idx_d = sample_idx;
                        width_d    = WD_W'(1);
                    end
                end
                TRACK: begin
                    if (!above) begin
                        emit    = 1'b1;
                        state_d = REFRACT;
                        rcnt_d  = RC_W'(REFRACT_LEN);
                    end else begin
                        // Strict compare keeps the earliest of equal maxima.
                        if (amp_q > cand_amp_q) begin
                            cand_amp_d = amp_q;
                            cand_idx_d = sample_idx;
                        end
                        width_d = width_q + WD_W'(1);
                        if (width_d == WD_W'(MAX_WIDTH)) begin
                            emit    = 1'b1;
                            state_d = REFRACT;
                            rcnt_d  = RC_W'(REFRACT_LEN);
                        end
                    end
                end
                REFRACT: begin
                    rcnt_d = rcnt_q - RC_W'(1);
                    if (rcnt_q == RC_W'(1)) begin
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= SEARCH;
            cand_amp_q <= '0;
            cand_idx_q <= '0;
            width_q    <= '0;
            rcnt_q     <= '0;
            sample_idx <= '0;
        end else begin
            state_q    <= state_d;
            cand_amp_q <= cand_amp_d;
            cand_idx_q <= cand_idx_d;
            width_q    <= width_d;
            rcnt_q     <= rcnt_d;
            if (amp_valid) begin
                sample_idx <= sample_idx + 32'd1;
            end
        end
    end

    // Peak level tracks 3/4 old level plus 1/4 of the emitted amplitude.
    assign pkl_mix = {1'b0, pkl_q, 1'b0} + {2'b00, pkl_q} + {2'b00, cand_amp_d};

    always_ff @(posedge clk) begin
        if (!rst) begin
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_amp   <= '0;
            beat_count <= '0;
            pkl_q      <= OUT_W'(PKL_INIT);
        end else begin
            peak_valid <= emit;
            if (emit) begin
                peak_idx <= cand_idx_d;
                peak_amp <= cand_amp_d;
                pkl_q    <= pkl_mix[OUT_W+1:2];
                if (beat_count != 16'hFFFF) begin
                    beat_count <= beat_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecg_rpeak_detector.sv
// Self-checking bench for ecg_rpeak_detector: directed requantize/peak cases
// plus randomized streams checked against a sample-level reference model.
module tb_ecg_rpeak_detector;

    localparam int IN_W        = 38;
    localparam int OUT_W       = 16;
    localparam int REFRACT_LEN = 72;
    localparam int MAX_WIDTH   = 36;
    localparam int PKL_INIT    = 4000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [IN_W-1:0]  y_in = '0;
    logic signed [OUT_W-1:0] y_q;
    logic                    y_q_valid;
    logic                    peak_valid;
    logic [31:0]             peak_idx;
    logic [OUT_W-1:0]        peak_amp;
    logic [15:0]             beat_count;

    always #5 clk = ~clk;

    ecg_rpeak_detector #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .SHIFT       (15),
        .PKL_INIT    (PKL_INIT),
        .REFRACT_LEN (REFRACT_LEN),
        .MAX_WIDTH   (MAX_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .y_in       (y_in),
        .y_q        (y_q),
        .y_q_valid  (y_q_valid),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .peak_amp   (peak_amp),
        .beat_count (beat_count)
    );

    typedef struct { longint v; int edge_n; } yq_t;
    typedef struct { int idx; int amp; int end_i; } pk_t;
    typedef struct { longint idx; longint amp; int edge_n; longint beats; } obs_t;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    yq_t  yq_exp[$];
    int   seg_edge[$];
    int   seg_amp[$];
    obs_t dut_pk[$];
    pk_t  exp_pk[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        yq_t e;
        if (y_q_valid) begin
            if (yq_exp.size() == 0) begin
                check("yq_unexpected", y_q_valid, 0);
            end else begin
                e = yq_exp.pop_front();
                check("yq", y_q, e.v);
                check("yq_latency", cyc, e.edge_n);
            end
        end else if (yq_exp.size() > 0 && yq_exp[0].edge_n <= cyc) begin
            e = yq_exp.pop_front();
            check("yq_missing", y_q_valid, 1);
        end
        if (peak_valid) begin
            dut_pk.push_back('{longint'(peak_idx), longint'(peak_amp), cyc, longint'(beat_count)});
        end
    end

    function automatic int requant_model(input longint y);
        longint r;
        r = (y + 16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic send_y(input longint y, input int gaps, input longint yq);
        logic signed [IN_W-1:0] v;
        v = y[IN_W-1:0];
        repeat (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        y_in     = v;
        seg_edge.push_back(cyc + 1);
        seg_amp.push_back(yq < 0 ? (yq == -32768 ? 32767 : int'(-yq)) : int'(yq));
        yq_exp.push_back('{yq, cyc + 1});
    endtask

    task automatic send_q(input int q, input int gaps);
        send_y(longint'(q) * 32768, gaps, longint'(q));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic apply_reset(input bit chk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        y_in     = '0;
        @(negedge clk);
        if (chk) begin
            check("rst_y_q", y_q, 0);
            check("rst_y_q_valid", y_q_valid, 0);
            check("rst_peak_valid", peak_valid, 0);
            check("rst_peak_idx", peak_idx, 0);
            check("rst_peak_amp", peak_amp, 0);
            check("rst_beat_count", beat_count, 0);
        end
        rst = 1'b1;
        yq_exp.delete();
        seg_edge.delete();
        seg_amp.delete();
        dut_pk.delete();
        exp_pk.delete();
    endtask

    task automatic check_peaks(input string tag);
        check({tag, "_count"}, dut_pk.size(), exp_pk.size());
        for (int i = 0; i < exp_pk.size() && i < dut_pk.size(); i++) begin
            check({tag, "_idx"}, dut_pk[i].idx, exp_pk[i].idx);
            check({tag, "_amp"}, dut_pk[i].amp, exp_pk[i].amp);
            check({tag, "_when"}, dut_pk[i].edge_n, seg_edge[exp_pk[i].end_i] + 2);
            check({tag, "_beats"}, dut_pk[i].beats, i + 1);
        end
    endtask

    // Reference detector: scans the magnitude sequence with lookahead, one peak at a time.
    task automatic build_expected();
        int pkl, i, n, thr, best, len, end_i;
        pkl = PKL_INIT;
        i = 0;
        n = seg_amp.size();
        exp_pk.delete();
        while (i < n) begin
            thr = pkl / 2;
            if (seg_amp[i] > thr) begin
                best = i;
                len  = 1;
                while (len < MAX_WIDTH && i + len < n && seg_amp[i + len] > thr) begin
                    if (seg_amp[i + len] > seg_amp[best]) best = i + len;
                    len++;
                end
                if (len == MAX_WIDTH)  end_i = i + len - 1;
                else if (i + len < n)  end_i = i + len;
                else break;
                exp_pk.push_back('{best, seg_amp[best], end_i});
                pkl = (3 * pkl + seg_amp[best]) / 4;
                i = end_i + REFRACT_LEN + 1;
            end else begin
                i++;
            end
        end
    endtask

    function automatic int basic_val(input int i);
        case (i)
            10: return 2500;
            11: return 3000;
            12: return 3500;
            13: return 3000;
            14: return 1500;
            default: return 0;
        endcase
    endfunction

    initial begin
        int q, burst_left, burst_amp, gaps;
        bit burst_neg;
        longint y;
        logic [63:0] r64;

        apply_reset(1'b1);

        // Requantize, rounding and saturation; the -32768 sample starts a peak of magnitude 32767.
        send_y(longint'(1000) * 32768, 0, 1000);
        send_y(longint'(5) * 32768 + 16384, 0, 6);
        send_y(-(longint'(5) * 32768 + 16384), 0, -5);
        send_y(-(longint'(1) <<< 37), 0, -32768);
        send_y(longint'(1) <<< 36, 0, 32767);
        for (int i = 0; i < 15; i++) send_q(0, 0);
        idle(6);
        exp_pk.push_back('{3, 32767, 5});
        check_peaks("requant");

        // Basic peak, refractory masking, updated threshold (strictly above 1828).
        apply_reset(1'b0);
        for (int i = 0; i < 200; i++) begin
            q = basic_val(i);
            if (i == 20 || i == 87) q = 3000;
            if (i == 165) q = 1828;
            if (i == 170) q = 1830;
            send_q(q, 0);
        end
        idle(6);
        exp_pk.push_back('{12, 3500, 14});
        exp_pk.push_back('{87, 3000, 88});
        exp_pk.push_back('{170, 1830, 171});
        check_peaks("basic");

        // Width limit.
        apply_reset(1'b0);
        for (int i = 0; i < 200; i++) send_q((i >= 100 && i < 150) ? 2500 : 0, 0);
        idle(6);
        exp_pk.push_back('{100, 2500, 135});
        check_peaks("width");

        // Basic peak with in_valid toggling every other cycle.
        apply_reset(1'b0);
        for (int i = 0; i < 40; i++) send_q(basic_val(i), 1);
        idle(8);
        exp_pk.push_back('{12, 3500, 14});
        check_peaks("gaps");

        // Reset while tracking a second peak.
        apply_reset(1'b0);
        for (int i = 0; i < 94; i++) send_q((i == 91 || i == 92) ? 3000 : basic_val(i), 0);
        exp_pk.push_back('{12, 3500, 14});
        check_peaks("pre_rst");
        apply_reset(1'b1);
        for (int i = 0; i < 120; i++) send_q(0, 0);
        idle(6);
        check_peaks("post_rst");

        // Randomized streams against the reference model.
        for (int s = 0; s < 4; s++) begin
            apply_reset(1'b0);
            burst_left = 0;
            burst_amp  = 0;
            burst_neg  = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if (burst_left == 0 && $urandom_range(0, 99) < 3) begin
                    burst_left = int'($urandom_range(1, 45));
                    burst_amp  = int'($urandom_range(800, 25000));
                    burst_neg  = ($urandom_range(0, 3) == 0);
                end
                if ($urandom_range(0, 99) < 2) begin
                    r64 = {$urandom(), $urandom()};
                    y = longint'($signed(r64[IN_W-1:0]));
                end else begin
                    if (burst_left > 0) begin
                        q = burst_amp + int'($urandom_range(0, 400)) - 200;
                        if (burst_neg) q = -q;
                        burst_left--;
                    end else begin
                        q = int'($urandom_range(0, 600)) - 300;
                    end
                    y = longint'(q) * 32768;
                    if ($urandom_range(0, 7) == 0) y = y + 16384;
                    else y = y + longint'($urandom_range(0, 32767)) - 16384;
                end
                gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                send_y(y, gaps, longint'(requant_model(y)));
            end
            for (int i = 0; i < 60; i++) send_q(0, 0);
            idle(6);
            build_expected();
            check_peaks("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
